char_rotate_ctrl: RTL and testbench
===================================

Name: char_rotate_ctrl

Overview:
- Sequencer for the 3-character rotating word display (codes d/E/1/blank, 2 bits each).
- Captures the three character codes and generates the 2-bit rotation select that drives the three 3-to-1 character muxes feeding HEX2..HEX0.
- Rotation is either automatic on a prescaled tick or manual by single-step.
- Replaces the manual select switches; the downstream mux and 7-seg decode logic are unchanged.

Parameters:
- TICK_DIV, 50000000: clock cycles per rotation step (1 s at 50 MHz); must be >= 1.
- CNT_W, 26: prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Load  input  1  level; when high on an edge, captures CodeU/CodeV/CodeW.
- CodeU  input  2  first character code.
- CodeV  input  2  second character code.
- CodeW  input  2  third character code.
- Run  input  1  level; 1 = auto-rotate, 0 = pause.
- Step  input  1  manual advance; acts on its rising edge only.
- Sel  output  2  rotation select to the muxes; takes only the values 00, 01, 10.
- U  output  2  registered captured CodeU.
- V  output  2  registered captured CodeV.
- W  output  2  registered captured CodeW.
- LoadAck  output  1  one-cycle pulse, the cycle after a load is captured.
- Tick  output  1  one-cycle pulse on each automatic advance.
- Running  output  1  high while in state RUN.

Behaviour:
- Reset (Resetn=0 at an edge):
  - state=IDLE; Sel=00; U=V=W=11 (blank).
  - Prescaler count=0; LoadAck=0; Tick=0; Running=0.
  - Step edge-detect register cleared to 0.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - Sel holds 00 and the counter holds 0.
  - Run and Step are ignored. Only Load leaves IDLE.
- Load (any state; highest priority):
  - Next edge: U/V/W <= CodeU/V/W; Sel <= 00; count <= 0.
  - Next state = RUN if Run=1, else PAUSE.
  - LoadAck=1 for that following cycle only.
  - Load held high recaptures every cycle, LoadAck stays high, and no advance occurs.
- RUN:
  - count increments each cycle.
  - When count == TICK_DIV-1: count <= 0, Sel advances, Tick=1 for one cycle.
  - Run=0 at an edge moves to PAUSE; count holds its value and no Tick is issued that cycle, even at terminal count.
- PAUSE:
  - count holds.
  - Step rising edge (Step=1, previous Step=0) advances Sel by exactly one; Tick stays 0.
  - Run=1 moves to RUN; count resumes from its held value.
- Step in RUN is ignored. The edge detector still tracks Step every cycle in all states, so a Step held through a RUN-to-PAUSE transition gives no advance.
- Sel advance sequence: 00 -> 01 -> 10 -> 00 (wrap). 11 is never produced.
- Priority per edge: Resetn > Load > Run-level transition > Step / terminal count.
- Latency: Sel changes on the same edge that registers the advance. Tick and Sel update together.
- Edge case: TICK_DIV=1 advances Sel every cycle in RUN, with Tick held high continuously.
- Running = (state == RUN), registered.

Optional Feature:
- Macro: CHAR_ROTATE_REVERSE_EN.
- When defined:
  - Extra input port Dir, 1 bit.
  - Dir=1 reverses both auto and step advance: 00 -> 10 -> 01 -> 00.
  - Dir is sampled on the advancing edge; a change mid-sequence takes effect at the next advance with no skipped state.
- When undefined: no Dir port; forward sequence only.

Test Plan (TICK_DIV=4, CNT_W=3):
- Reset, then Load=1 for one cycle with U=00, V=01, W=10 and Run=0 -> next cycle LoadAck=1, U/V/W=00/01/10, Sel=00, Running=0; LoadAck=0 the cycle after.
- Run=1 after load -> Tick pulses every 4th cycle; Sel goes 00, 01, 10, 00 at ticks 1, 2, 3; never 11.
- In RUN, drop Run at count=2 for 5 cycles, then raise it -> no Tick during the pause; the first Tick comes 2 cycles after resume.
- In PAUSE, Step held high for 3 cycles, then low, then high again -> Sel advances exactly twice in total. Step pulses while in RUN or IDLE -> no change.
- Load asserted on the same edge as a terminal count in RUN -> Sel=00, count=0, no Tick, LoadAck=1.
- Resetn=0 mid-rotation with Sel=10 -> next edge Sel=00, U=V=W=11, state IDLE; Run=1 without Load -> no Tick ever.
- With CHAR_ROTATE_REVERSE_EN defined: Dir=1 in RUN -> Sel goes 00, 10, 01, 00.

Source files
------------

// File: rtl/char_rotate_if.sv
// Handshake bundle between the rotation sequencer and its controller/display side.
// Dir exists only when CHAR_ROTATE_REVERSE_EN is defined.
interface char_rotate_if;
   logic       Load;
   logic [1:0] CodeU;
   logic [1:0] CodeV;
   logic [1:0] CodeW;
   logic       Run;
   logic       Step;
`ifdef CHAR_ROTATE_REVERSE_EN
   logic       Dir;
`endif
   logic [1:0] Sel;
   logic [1:0] U;
   logic [1:0] V;
   logic [1:0] W;
   logic       LoadAck;
   logic       Tick;
   logic       Running;

   modport master (
      output Load, CodeU, CodeV, CodeW, Run, Step,
`ifdef CHAR_ROTATE_REVERSE_EN
      output Dir,
`endif
      input  Sel, U, V, W, LoadAck, Tick, Running
   );

   modport slave (
      input  Load, CodeU, CodeV, CodeW, Run, Step,
`ifdef CHAR_ROTATE_REVERSE_EN
      input  Dir,
`endif
      output Sel, U, V, W, LoadAck, Tick, Running
   );
endinterface

// File: rtl/char_rotate_ctrl.sv
// Rotation sequencer for the 3-character word display: captures codes, produces the mux select.
// Optional reverse rotation via CHAR_ROTATE_REVERSE_EN (adds Dir).
//
// state | meaning
// IDLE  | after reset, waiting for the first Load; Sel=00, count=0
// RUN   | auto-rotate, Sel advances every TICK_DIV cycles
// PAUSE | count frozen, Sel advances on Step rising edge
module char_rotate_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input logic          Clock,
   input logic          Resetn,
   char_rotate_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       sel, sel_nx;
   logic [1:0]       u, u_nx, v, v_nx, w, w_nx;
   logic             load_ack, tick, tick_nx, running;
   logic             step_q, step_rise, rev;

`ifdef CHAR_ROTATE_REVERSE_EN
   assign rev = bus.Dir;
`else
   assign rev = 1'b0;
`endif

   // 11 is never produced; any other value falls back to 00.
   function automatic logic [1:0] advance(input logic [1:0] s, input logic r);
      logic [1:0] n;
      n = 2'b00;
      if (r) begin
         case (s)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b01;
            default: n = 2'b00;
         endcase
      end else begin
         case (s)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b10;
            default: n = 2'b00;
         endcase
      end
      return n;
   endfunction

   assign step_rise = bus.Step & ~step_q;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      sel_nx   = sel;
      u_nx     = u;
      v_nx     = v;
      w_nx     = w;
      tick_nx  = 1'b0;
      if (bus.Load) begin
         u_nx     = bus.CodeU;
         v_nx     = bus.CodeV;
         w_nx     = bus.CodeW;
         sel_nx   = 2'b00;
         cnt_nx   = '0;
         state_nx = bus.Run ? RUN : PAUSE;
      end else begin
         case (state)
            RUN: begin
               if (!bus.Run) begin
                  state_nx = PAUSE;
               end else if (cnt == TERM) begin
                  cnt_nx  = '0;
                  sel_nx  = advance(sel, rev);
                  tick_nx = 1'b1;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (bus.Run) begin
                  state_nx = RUN;
               end else if (step_rise) begin
                  sel_nx = advance(sel, rev);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         sel      <= 2'b00;
         u        <= 2'b11;
         v        <= 2'b11;
         w        <= 2'b11;
         load_ack <= 1'b0;
         tick     <= 1'b0;
         running  <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         sel      <= sel_nx;
         u        <= u_nx;
         v        <= v_nx;
         w        <= w_nx;
         load_ack <= bus.Load;
         tick     <= tick_nx;
         running  <= (state_nx == RUN);
         step_q   <= bus.Step;
      end
   end

   assign bus.Sel     = sel;
   assign bus.U       = u;
   assign bus.V       = v;
   assign bus.W       = w;
   assign bus.LoadAck = load_ack;
   assign bus.Tick    = tick;
   assign bus.Running = running;

endmodule

// File: tb/tb_char_rotate_ctrl.sv
// Self-checking bench for char_rotate_ctrl against a cycle-level behavioural model.
// Reverse-rotation scenario is included when CHAR_ROTATE_REVERSE_EN is defined.
module tb_char_rotate_ctrl;
   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 3;

   logic clk = 1'b0;
   logic rstn;
   int   vectors = 0;
   int   miscompares = 0;

   char_rotate_if bus ();

   char_rotate_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .Clock (clk),
      .Resetn(rstn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // mode: 0 idle, 1 run, 2 pause; pos is the select value as a number 0..2
   int         m_mode = 0;
   int         m_cnt  = 0;
   int         m_pos  = 0;
   logic [1:0] m_u = 2'b11, m_v = 2'b11, m_w = 2'b11;
   logic       m_ack = 0, m_tick = 0, m_run = 0, m_sprev = 0;

   function automatic logic [10:0] obs();
      return {bus.Sel, bus.U, bus.V, bus.W, bus.LoadAck, bus.Tick, bus.Running};
   endfunction

   function automatic logic [10:0] expv();
      return {2'(m_pos), m_u, m_v, m_w, m_ack, m_tick, m_run};
   endfunction

   // One rising edge: model consumes the same inputs the DUT sees, then settle.
   task automatic clk_edge();
      bit d;
      @(posedge clk);
`ifdef CHAR_ROTATE_REVERSE_EN
      d = bus.Dir;
`else
      d = 0;
`endif
      if (!rstn) begin
         m_mode = 0; m_cnt = 0; m_pos = 0;
         m_u = 2'b11; m_v = 2'b11; m_w = 2'b11;
         m_ack = 0; m_tick = 0; m_sprev = 0;
      end else begin
         m_ack  = bus.Load;
         m_tick = 0;
         if (bus.Load) begin
            m_u = bus.CodeU; m_v = bus.CodeV; m_w = bus.CodeW;
            m_pos = 0; m_cnt = 0;
            m_mode = bus.Run ? 1 : 2;
         end else if (m_mode == 1) begin
            if (!bus.Run) m_mode = 2;
            else if (m_cnt == TICK_DIV - 1) begin
               m_cnt = 0; m_tick = 1;
               m_pos = d ? (m_pos + 2) % 3 : (m_pos + 1) % 3;
            end else m_cnt++;
         end else if (m_mode == 2) begin
            if (bus.Run) m_mode = 1;
            else if (bus.Step && !m_sprev)
               m_pos = d ? (m_pos + 2) % 3 : (m_pos + 1) % 3;
         end
         m_sprev = bus.Step;
      end
      m_run = (m_mode == 1);
      #1;
   endtask

   task automatic set_in(input bit l, input bit r, input bit s);
      bus.Load = l; bus.Run = r; bus.Step = s;
   endtask

   task automatic do_load(input logic [1:0] cu, input logic [1:0] cv, input logic [1:0] cw,
                          input bit r);
      bus.CodeU = cu; bus.CodeV = cv; bus.CodeW = cw;
      set_in(1, r, 0);
      clk_edge();
      bus.Load = 0;
   endtask

   task automatic test_reset();
      rstn = 0;
      set_in(0, 0, 0);
      bus.CodeU = 0; bus.CodeV = 0; bus.CodeW = 0;
      repeat (2) clk_edge();
      vectors++;
      if (obs() !== 11'b00_11_11_11_000) begin
         miscompares++;
         $display("FAIL reset: got %b want %b", obs(), 11'b00_11_11_11_000);
      end
      rstn = 1;
   endtask

   task automatic test_load();
      do_load(2'b00, 2'b01, 2'b10, 0);
      vectors++;
      if (obs() !== 11'b00_00_01_10_100) begin
         miscompares++;
         $display("FAIL load_capture: got %b want %b", obs(), 11'b00_00_01_10_100);
      end
      clk_edge();
      vectors++;
      if (bus.LoadAck !== 1'b0 || obs() !== expv()) begin
         miscompares++;
         $display("FAIL load_ack_drop: got %b want %b", obs(), expv());
      end
   endtask

   task automatic test_auto_rotate();
      int ticks = 0;
      int bad11 = 0;
      bus.Run = 1;
      for (int i = 0; i < 14; i++) begin
         clk_edge();
         if (bus.Tick === 1'b1) ticks++;
         if (bus.Sel === 2'b11) bad11++;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL auto_rotate c%0d: got %b want %b", i, obs(), expv());
         end
      end
      // first edge only enters RUN; ticks land on edges 5, 9, 13
      vectors++;
      if (ticks != 3 || bad11 != 0 || bus.Sel !== 2'b00) begin
         miscompares++;
         $display("FAIL auto_rotate_count: ticks=%0d sel11=%0d sel=%b want 3/0/00",
                  ticks, bad11, bus.Sel);
      end
   endtask

   task automatic test_pause_resume();
      int n = 0;
      int tick_seen = 0;
      while (m_cnt != 2 && n < 20) begin clk_edge(); n++; end
      bus.Run = 0;
      for (int i = 0; i < 5; i++) begin
         clk_edge();
         if (bus.Tick !== 1'b0) tick_seen++;
      end
      vectors++;
      if (tick_seen != 0 || bus.Running !== 1'b0 || obs() !== expv()) begin
         miscompares++;
         $display("FAIL pause_hold: ticks=%0d got %b want %b", tick_seen, obs(), expv());
      end
      bus.Run = 1;
      n = 0;
      do begin clk_edge(); n++; end while (bus.Tick !== 1'b1 && n < 10);
      // resume edge restores RUN, then count 2->3, then terminal
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL resume_latency: edges=%0d want 3", n);
      end
   endtask

   task automatic test_step();
      logic [1:0] s0;
      int pat[6] = '{1, 1, 1, 0, 1, 0};
      bus.Run = 0;
      clk_edge();
      s0 = bus.Sel;
      foreach (pat[i]) begin
         bus.Step = pat[i][0];
         clk_edge();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL step_pause c%0d: got %b want %b", i, obs(), expv());
         end
      end
      vectors++;
      if (bus.Sel !== 2'((int'(s0) + 2) % 3)) begin
         miscompares++;
         $display("FAIL step_twice: got %b want %b", bus.Sel, 2'((int'(s0) + 2) % 3));
      end
      bus.Run = 1;
      for (int i = 0; i < 10; i++) begin
         bus.Step = i[0];
         clk_edge();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL step_in_run c%0d: got %b want %b", i, obs(), expv());
         end
      end
      bus.Step = 0;
   endtask

   task automatic test_load_at_terminal();
      int n = 0;
      bus.Run = 1;
      while (!(m_mode == 1 && m_cnt == TICK_DIV - 1) && n < 20) begin clk_edge(); n++; end
      bus.CodeU = 2'b11; bus.CodeV = 2'b10; bus.CodeW = 2'b01;
      bus.Load = 1;
      clk_edge();
      bus.Load = 0;
      vectors++;
      if (obs() !== 11'b00_11_10_01_101) begin
         miscompares++;
         $display("FAIL load_at_terminal: got %b want %b", obs(), 11'b00_11_10_01_101);
      end
      // count was cleared, so the next tick is a full period away
      n = 0;
      do begin clk_edge(); n++; end while (bus.Tick !== 1'b1 && n < 10);
      vectors++;
      if (n != TICK_DIV) begin
         miscompares++;
         $display("FAIL load_clears_count: edges=%0d want %0d", n, TICK_DIV);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int tick_seen = 0;
      bus.Run = 1;
      while (m_pos != 2 && n < 30) begin clk_edge(); n++; end
      rstn = 0;
      clk_edge();
      rstn = 1;
      vectors++;
      if (obs() !== 11'b00_11_11_11_000) begin
         miscompares++;
         $display("FAIL reset_mid: got %b want %b", obs(), 11'b00_11_11_11_000);
      end
      for (int i = 0; i < 20; i++) begin
         bus.Step = i[1];
         clk_edge();
         if (bus.Tick !== 1'b0 || bus.Sel !== 2'b00 || bus.Running !== 1'b0) tick_seen++;
      end
      bus.Step = 0;
      vectors++;
      if (tick_seen != 0) begin
         miscompares++;
         $display("FAIL idle_ignores_run_step: bad_cycles=%0d want 0", tick_seen);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 600; i++) begin
         rstn      = ($urandom_range(0, 79) != 0);
         bus.Load  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 5) == 0) bus.Run = ~bus.Run;
         bus.Step  = ($urandom_range(0, 2) == 0);
         bus.CodeU = 2'($urandom);
         bus.CodeV = 2'($urandom);
         bus.CodeW = 2'($urandom);
`ifdef CHAR_ROTATE_REVERSE_EN
         if ($urandom_range(0, 7) == 0) bus.Dir = ~bus.Dir;
`endif
         clk_edge();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            errs++;
            if (errs < 10) $display("FAIL random c%0d: got %b want %b", i, obs(), expv());
         end
      end
      rstn = 1;
      set_in(0, 0, 0);
`ifdef CHAR_ROTATE_REVERSE_EN
      bus.Dir = 0;
`endif
   endtask

`ifdef CHAR_ROTATE_REVERSE_EN
   task automatic test_reverse();
      logic [1:0] seq[3];
      int k = 0;
      int n = 0;
      bus.Dir = 1;
      do_load(2'b01, 2'b10, 2'b00, 1);
      while (k < 3 && n < 40) begin
         clk_edge(); n++;
         if (bus.Tick === 1'b1) begin seq[k] = bus.Sel; k++; end
      end
      vectors++;
      if (k != 3 || seq[0] !== 2'b10 || seq[1] !== 2'b01 || seq[2] !== 2'b00) begin
         miscompares++;
         $display("FAIL reverse_seq: got %b %b %b want 10 01 00", seq[0], seq[1], seq[2]);
      end
      bus.Dir = 0;
   endtask
`endif

   initial begin
      rstn = 0;
      set_in(0, 0, 0);
`ifdef CHAR_ROTATE_REVERSE_EN
      bus.Dir = 0;
`endif
      test_reset();
      test_load();
      test_auto_rotate();
      test_pause_resume();
      test_step();
      test_load_at_terminal();
      test_reset_mid();
`ifdef CHAR_ROTATE_REVERSE_EN
      test_reverse();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
